align_shift_pipe: RTL
=====================

ALIGN_SHIFT_PIPE -- requirements
Module: align_shift_pipe

Interface
REQ-001 SHALL have parameter PP_W, default 3, magnitude bits of the partial product, leading one included.
REQ-002 SHALL have parameter EXP_W, default 6, exponent width.
REQ-003 SHALL have parameter OUT_W, default 15, two's-complement aligned output width; magnitude field M = OUT_W-1; PP_W <= M is required.
REQ-004 SHALL have parameter SB_W, default 5, sideband (Q_frac) width.
REQ-005 SHALL have port i_clk, input, 1, sole clock; all flops on the rising edge.
REQ-006 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port i_valid, input, 1, upstream data valid.
REQ-008 SHALL have port o_ready, output, 1, block accepts input this cycle.
REQ-009 SHALL have port i_denorm_pp, input, PP_W+1, {sign, magnitude}.
REQ-010 SHALL have port i_exp, input, EXP_W, partial-product exponent.
REQ-011 SHALL have port i_max_exp, input, EXP_W, alignment target exponent.
REQ-012 SHALL have port i_Q_frac, input, SB_W, sideband carried with the data.
REQ-013 SHALL have port o_valid, output, 1, output data valid.
REQ-014 SHALL have port i_ready, input, 1, downstream accepts.
REQ-015 SHALL have port o_align_pp, output, OUT_W, aligned signed partial product.
REQ-016 SHALL have port o_sticky, output, 1, OR of magnitude bits shifted out.
REQ-017 SHALL have port o_underflow, output, 1, i_exp > i_max_exp for this item.
REQ-018 SHALL have port o_Q_frac, output, SB_W, sideband aligned to o_align_pp.

Function
REQ-019 SHALL be a 2-stage pipeline: S1 registers diff = i_max_exp - i_exp (EXP_W+1 bits, borrow kept), sign, magnitude, sideband; S2 registers shifted, signed result, sticky, underflow, sideband.
REQ-020 SHALL give latency 2 cycles from accepted input to o_valid with no backpressure, throughput 1 item/cycle.
REQ-021 SHALL compute the unsigned value as (mag << (M-PP_W)) >> diff; diff >= M yields 0.
REQ-022 SHALL set o_sticky = 1 iff any nonzero magnitude bit is dropped by the right shift.
REQ-023 SHALL, on negative diff (borrow), set o_underflow = 1, o_align_pp = 0, o_sticky = 0.
REQ-024 SHALL form o_align_pp as {0, value} if sign = 0, else its two's complement in OUT_W bits; a zero value gives 0 regardless of sign.
REQ-025 SHALL advance stage k when stage k is empty or stage k+1 advances this cycle; o_ready = !S1_valid || S1 advances.
REQ-026 SHALL hold o_align_pp, o_sticky, o_underflow, o_Q_frac and o_valid stable while o_valid && !i_ready.
REQ-027 SHALL neither drop nor duplicate items and SHALL preserve order; simultaneous accept at input and output when full is legal.
REQ-028 SHALL ignore data inputs when i_valid = 0 or o_ready = 0.

Reset
REQ-029 SHALL, on i_rst = 1 at a clock edge, clear both stage valids; o_valid = 0, o_ready = 1 the following cycle.
REQ-030 SHALL reset o_align_pp, o_sticky, o_underflow, o_Q_frac to 0.
REQ-031 SHALL discard in-flight items when reset is asserted mid-stream; i_rst overrides a simultaneous i_valid.

Structure
REQ-032 SHALL take default widths (PP_W, EXP_W, OUT_W, SB_W) from shared package align_pkg.
REQ-033 SHALL implement the shift and sticky logic in one combinational sub-module, align_shifter (params PP_W, M, EXP_W+1), instanced in S2.
REQ-034 SHALL contain no clock gating and no latches.

Verification
REQ-035 SHALL cover: pp=4'b0110, exp=max_exp=8, i_ready=1 -> o_align_pp=15'h3000, sticky 0, o_valid 2 cycles later.
REQ-036 SHALL cover: pp=4'b1101, max=20, exp=9 (diff 11) -> o_align_pp=15'h7FFB, sticky 0.
REQ-037 SHALL cover: pp=4'b0101, diff 13 -> o_align_pp=15'h0001, sticky 1; diff 20 -> 15'h0000, sticky 1.
REQ-038 SHALL cover: exp=10, max=8 -> o_align_pp 0, o_underflow 1, Q_frac passed through.
REQ-039 SHALL cover: 4 back-to-back items, i_ready held 0 for 3 cycles -> o_ready drops after 2 accepted, output stable, all 4 emerge in order once released.
REQ-040 SHALL cover: i_rst pulsed with 2 items in flight -> o_valid 0 next cycle, no stale item emitted afterwards.

Source files
------------

// File: rtl/align_pkg.sv
// rtl/align_pkg.sv - shared default widths for the alignment shift pipeline
package align_pkg;

    localparam int ALIGN_PP_W  = 3;
    localparam int ALIGN_EXP_W = 6;
    localparam int ALIGN_OUT_W = 15;
    localparam int ALIGN_SB_W  = 5;

endpackage

// File: rtl/align_shifter.sv
// rtl/align_shifter.sv - left-justify a magnitude into M bits, right shift it, flag lost bits
module align_shifter #(
    parameter int PP_W = 3,
    parameter int M    = 14,
    parameter int DW   = 7
) (
    input  logic [PP_W-1:0] i_mag,
    input  logic [DW-1:0]   i_shamt,
    output logic [M-1:0]    o_value,
    output logic            o_sticky
);

    localparam logic [DW-1:0] M_AMT = DW'(M);

    logic [M-1:0] ext;
    logic [M-1:0] kept;

    always_comb begin
        ext      = M'(i_mag) << (M - PP_W);
        kept     = '0;
        o_value  = '0;
        o_sticky = 1'b0;
        if (i_shamt >= M_AMT) begin
            // everything falls off the bottom: any set magnitude bit is lost
            o_sticky = |i_mag;
        end else begin
            o_value  = ext >> i_shamt;
            kept     = o_value << i_shamt;
            o_sticky = (kept != ext);
        end
    end

endmodule

// File: rtl/align_shift_pipe.sv
// rtl/align_shift_pipe.sv - two-stage exponent-difference alignment of a signed partial product
module align_shift_pipe
    import align_pkg::*;
#(
    parameter int PP_W  = ALIGN_PP_W,
    parameter int EXP_W = ALIGN_EXP_W,
    parameter int OUT_W = ALIGN_OUT_W,
    parameter int SB_W  = ALIGN_SB_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [PP_W:0]    i_denorm_pp,
    input  logic [EXP_W-1:0] i_exp,
    input  logic [EXP_W-1:0] i_max_exp,
    input  logic [SB_W-1:0]  i_Q_frac,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [OUT_W-1:0] o_align_pp,
    output logic             o_sticky,
    output logic             o_underflow,
    output logic [SB_W-1:0]  o_Q_frac
);

    localparam int M  = OUT_W - 1;
    localparam int DW = EXP_W + 1;

    logic             s1_valid_q, s1_valid_d;
    logic [DW-1:0]    s1_diff_q, s1_diff_d;
    logic             s1_sign_q, s1_sign_d;
    logic [PP_W-1:0]  s1_mag_q, s1_mag_d;
    logic [SB_W-1:0]  s1_sb_q, s1_sb_d;

    logic             s2_valid_q, s2_valid_d;
    logic [OUT_W-1:0] s2_pp_q, s2_pp_d;
    logic             s2_sticky_q, s2_sticky_d;
    logic             s2_uf_q, s2_uf_d;
    logic [SB_W-1:0]  s2_sb_q, s2_sb_d;

    logic             s1_adv;
    logic             s2_adv;
    logic             in_accept;
    logic [M-1:0]     sh_value;
    logic             sh_sticky;
    logic [OUT_W-1:0] mag_ext;

    align_shifter #(
        .PP_W (PP_W),
        .M    (M),
        .DW   (DW)
    ) u_shifter (
        .i_mag    (s1_mag_q),
        .i_shamt  (s1_diff_q),
        .o_value  (sh_value),
        .o_sticky (sh_sticky)
    );

    always_comb begin
        s2_adv    = !s2_valid_q || i_ready;
        s1_adv    = !s1_valid_q || s2_adv;
        in_accept = i_valid && s1_adv;

        s1_valid_d  = s1_valid_q;
        s1_diff_d   = s1_diff_q;
        s1_sign_d   = s1_sign_q;
        s1_mag_d    = s1_mag_q;
        s1_sb_d     = s1_sb_q;
        s2_valid_d  = s2_valid_q;
        s2_pp_d     = s2_pp_q;
        s2_sticky_d = s2_sticky_q;
        s2_uf_d     = s2_uf_q;
        s2_sb_d     = s2_sb_q;
        mag_ext     = {1'b0, sh_value};

        if (s1_adv) begin
            s1_valid_d = i_valid;
        end
        if (in_accept) begin
            // MSB of the widened difference is the borrow: set when i_exp > i_max_exp
            s1_diff_d = {1'b0, i_max_exp} - {1'b0, i_exp};
            s1_sign_d = i_denorm_pp[PP_W];
            s1_mag_d  = i_denorm_pp[PP_W-1:0];
            s1_sb_d   = i_Q_frac;
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_adv && s1_valid_q) begin
            s2_sb_d = s1_sb_q;
            if (s1_diff_q[DW-1]) begin
                s2_pp_d     = '0;
                s2_sticky_d = 1'b0;
                s2_uf_d     = 1'b1;
            end else begin
                s2_pp_d     = s1_sign_q ? (~mag_ext + OUT_W'(1)) : mag_ext;
                s2_sticky_d = sh_sticky;
                s2_uf_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q  <= 1'b0;
            s1_diff_q   <= '0;
            s1_sign_q   <= 1'b0;
            s1_mag_q    <= '0;
            s1_sb_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_pp_q     <= '0;
            s2_sticky_q <= 1'b0;
            s2_uf_q     <= 1'b0;
            s2_sb_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_diff_q   <= s1_diff_d;
            s1_sign_q   <= s1_sign_d;
            s1_mag_q    <= s1_mag_d;
            s1_sb_q     <= s1_sb_d;
            s2_valid_q  <= s2_valid_d;
            s2_pp_q     <= s2_pp_d;
            s2_sticky_q <= s2_sticky_d;
            s2_uf_q     <= s2_uf_d;
            s2_sb_q     <= s2_sb_d;
        end
    end

    assign o_ready     = s1_adv;
    assign o_valid     = s2_valid_q;
    assign o_align_pp  = s2_pp_q;
    assign o_sticky    = s2_sticky_q;
    assign o_underflow = s2_uf_q;
    assign o_Q_frac    = s2_sb_q;

endmodule
